filtro_azar: RTL
================

FILTRO_AZAR -- requirements
Module: filtro_azar

Interface
REQ-001 Parameter: N, default 3, minimum number of consecutive clock cycles a new input level must persist to be accepted; N SHALL be >= 2.
REQ-002 Parameter: CW, default 8, width of the glitch counter.
REQ-003 Port: clk  input  1  single system clock; all state SHALL change on its rising edge except for asynchronous reset.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: x  input  1  asynchronous, possibly hazard-prone signal, e.g. a combinational output with static hazards.
REQ-006 Port: clr  input  1  synchronous clear of the glitch counter, active high.
REQ-007 Port: y  output  1  filtered, registered version of x.
REQ-008 Port: glitch  output  1  one-cycle pulse flagging a rejected glitch.
REQ-009 Port: busy  output  1  high while a candidate level change is being qualified.
REQ-010 Port: count  output  CW  saturating count of rejected glitches.

Function
REQ-011 x SHALL pass through a two-flop synchronizer (f1 <= x; s <= f1) before any other use; no other logic SHALL read x.
REQ-012 Control SHALL be a two-state FSM with states STABLE and CAND, plus a qualification counter q of width ceil(log2(N))+1.
REQ-013 STABLE, s == y: remain in STABLE; q and y hold.
REQ-014 STABLE, s != y: go to CAND; q <= 1.
REQ-015 CAND, s == y: go to STABLE; q <= 0; glitch <= 1 for exactly one cycle; count <= count+1.
REQ-016 CAND, s != y and q == N-1: y <= s; go to STABLE; q <= 0; no glitch.
REQ-017 CAND, s != y and q < N-1: q <= q+1; stay in CAND.
REQ-018 y SHALL change only when s has differed from y on N consecutive rising edges; a stable x change SHALL appear on y at the (N+2)th rising edge, counting the first edge that samples the new x as edge 1.
REQ-019 Any excursion of s lasting 1 to N-1 cycles SHALL leave y unchanged and produce exactly one glitch pulse.
REQ-020 busy SHALL be registered and high exactly while the FSM is in CAND.
REQ-021 count SHALL saturate at 2^CW-1; further glitches SHALL still pulse glitch but SHALL NOT wrap count.
REQ-022 clr high at an edge: count <= 0; if a glitch is detected at the same edge, clr SHALL win (count = 0) and glitch SHALL still pulse.
REQ-023 A glitch pulse and a y update SHALL never occur on the same edge.
REQ-024 glitch, y, busy and count SHALL be registered outputs, with no combinational path from x or clr.

Reset
REQ-025 While rst_n = 0, independent of clk: f1 = 0, s = 0, y = 0, glitch = 0, busy = 0, count = 0, q = 0, state = STABLE.
REQ-026 Reset asserted mid-qualification (CAND) SHALL abort it immediately; no glitch pulse and no y update SHALL follow the release.
REQ-027 After rst_n rises, normal operation SHALL start at the first rising edge; if x = 1 at release, y SHALL reach 1 at edge N+2 with no glitch.

Verification (N = 3, CW = 8, 10 ns clock, x driven 1 ns after a rising edge)
REQ-028 Release reset with x = 0 for 10 cycles -> y = 0, glitch never high, busy never high, count = 0.
REQ-029 From y = 0, set x = 1 and hold -> busy high at edges 3-4, y = 1 at edge 5, glitch stays 0, count = 0; the same sequence SHALL hold for 1->0.
REQ-030 From y = 0, drive x high for 1 cycle, then separately for 2 cycles -> y stays 0, two single-cycle glitch pulses, count = 2.
REQ-031 Generate 300 two-cycle pulses -> count = 255 after the 255th pulse and stays 255; glitch pulses 300 times; then clr for one cycle -> count = 0.
REQ-032 Assert clr on the same edge that detects a glitch -> glitch = 1 for that cycle, count = 0 afterwards.
REQ-033 Pull rst_n low for 3 ns while busy = 1 between edges -> y, busy, glitch and count go to 0 before the next edge; with x held at 1, y rises 5 edges after the release.

Source files
------------

// File: rtl/filtro_azar.sv
// Glitch filter for a hazard-prone asynchronous input.
// x is synchronized, then a new level must persist for N consecutive
// cycles before it is accepted on y. Shorter excursions are rejected,
// flagged with a one-cycle glitch pulse and tallied in a saturating counter.
module filtro_azar #(
  parameter int N  = 3,  // qualification length in cycles, must be >= 2
  parameter int CW = 8   // glitch counter width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x,
  input  logic          clr,
  output logic          y,
  output logic          glitch,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam int QW = $clog2(N) + 1;
  localparam logic [QW-1:0] Q_LAST  = QW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {
    STABLE = 1'b0,
    CAND   = 1'b1
  } state_t;

  logic          f1;
  logic          s;
  state_t        state;
  state_t        state_nxt;
  logic [QW-1:0] q;
  logic [QW-1:0] q_nxt;
  logic          y_nxt;
  logic          glitch_nxt;

  // Two-flop synchronizer: the only logic that ever reads x.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples the pre-edge value; with blocking, s would copy x in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      f1 <= x;
      s  <= f1;
    end
  end

  // Next-state logic: qualify a candidate level or reject it as a glitch.
  // NOTE: every variable gets a default before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    y_nxt      = y;
    glitch_nxt = 1'b0;
    case (state)
      STABLE: begin
        if (s != y) begin
          state_nxt = CAND;
          q_nxt     = QW'(1);
        end
      end
      CAND: begin
        if (s == y) begin
          // Excursion ended before qualifying: reject it.
          state_nxt  = STABLE;
          q_nxt      = '0;
          glitch_nxt = 1'b1;
        end else if (q == Q_LAST) begin
          // Held for N consecutive edges: accept the new level.
          y_nxt     = s;
          state_nxt = STABLE;
          q_nxt     = '0;
        end else begin
          q_nxt = q + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE;
        q_nxt     = '0;
      end
    endcase
  end

  // FSM state and registered outputs; busy mirrors the next state so it
  // is a flop output that is high exactly while the FSM sits in CAND.
  // NOTE: the async reset clears every control flop, so a qualification
  // in progress is simply abandoned and cannot resume after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STABLE;
      q      <= '0;
      y      <= 1'b0;
      glitch <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      y      <= y_nxt;
      glitch <= glitch_nxt;
      busy   <= (state_nxt == CAND);
    end
  end

  // Saturating glitch counter; a synchronous clear beats a same-edge glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (glitch_nxt && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule
